// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with busy scoreboard; define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding
module reg_file_mp #(
  parameter int REG_COUNT = 32,
  parameter int REG_WIDTH = 32,
  parameter int ADR_WIDTH = 5,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD*ADR_WIDTH-1:0]    rd_addr_i,
  output logic [NUM_RD*REG_WIDTH-1:0]    rd_data_o,
  output logic [NUM_RD-1:0]              rd_busy_o,
  input  logic [NUM_WR-1:0]              wr_en_i,
  input  logic [NUM_WR*ADR_WIDTH-1:0]    wr_addr_i,
  input  logic [NUM_WR*REG_WIDTH-1:0]    wr_data_i,
  input  logic                           busy_set_i,
  input  logic [ADR_WIDTH-1:0]           busy_addr_i,
  output logic [ADR_WIDTH:0]             busy_cnt_o,
  output logic [REG_WIDTH-1:0]           a0
);
  localparam int A0_IDX = 10;
  localparam logic [ADR_WIDTH:0] ONE = 1;
  logic [REG_WIDTH-1:0] regs_q [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [ADR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADR_WIDTH-1:0] wa [NUM_WR];
  logic [REG_WIDTH-1:0] wd [NUM_WR];
  logic [ADR_WIDTH-1:0] ra [NUM_RD];
  logic [NUM_WR-1:0]    wr_ok, dec_ok;
  logic                 set_ok;

  // Unpack port buses; writes and busy sets aimed at x0 are dropped here
  always_comb begin
    set_ok = busy_set_i && busy_addr_i != '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wa[w]    = wr_addr_i[w*ADR_WIDTH +: ADR_WIDTH];
      wd[w]    = wr_data_i[w*REG_WIDTH +: REG_WIDTH];
      wr_ok[w] = wr_en_i[w] && wa[w] != '0;
    end
    for (int p = 0; p < NUM_RD; p++) ra[p] = rd_addr_i[p*ADR_WIDTH +: ADR_WIDTH];
  end

  // Scoreboard next state: clears first, then a set overrides a retiring producer; counter tracks actual bit flips
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    dec_ok = '0;
    for (int w = 0; w < NUM_WR; w++) if (wr_ok[w]) busy_d[wa[w]] = 1'b0;
    for (int w = 0; w < NUM_WR; w++) begin
      dec_ok[w] = wr_ok[w] && busy_q[wa[w]] && !(set_ok && busy_addr_i == wa[w]);
      for (int v = w + 1; v < NUM_WR; v++) if (wr_ok[v] && wa[v] == wa[w]) dec_ok[w] = 1'b0;
      if (dec_ok[w]) cnt_d = cnt_d - ONE;
    end
    if (set_ok && !busy_q[busy_addr_i]) cnt_d = cnt_d + ONE;
    if (set_ok) busy_d[busy_addr_i] = 1'b1;
  end

  // State update; later write ports land last so the highest index wins a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) if (wr_ok[w]) regs_q[wa[w]] <= wd[w];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Combinational read ports, optionally forwarding this cycle's winning write
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data_o[p*REG_WIDTH +: REG_WIDTH] = ra[p] == '0 ? '0 : regs_q[ra[p]];
      rd_busy_o[p] = ra[p] != '0 && busy_q[ra[p]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (!rst && wr_ok[w] && wa[w] == ra[p]) begin
          rd_data_o[p*REG_WIDTH +: REG_WIDTH] = wd[w];
          rd_busy_o[p] = set_ok && busy_addr_i == ra[p];
        end
      end
`endif
    end
  end

  assign busy_cnt_o = cnt_q;
  assign a0 = regs_q[A0_IDX];
endmodule
